// File: rtl/instr_dcd_burst_if.sv
// Bus bundle between the SPI byte deserialiser / register file and the
// instruction decoder. The decoder uses the slave modport; the SPI front end
// and register file side (or a testbench) use the master modport.
// With INSTR_DCD_BURST_ERR_EN defined, the bundle also carries the sticky err flag.
interface instr_dcd_burst_if #(
    parameter int ADDR_W = 6
);
    logic              cs_n;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_read;
    logic [7:0]        data_write;
    logic [7:0]        burst_cnt;
`ifdef INSTR_DCD_BURST_ERR_EN
    logic              err;
`endif

    modport master (
        output cs_n, byte_sync, data_in, data_read,
        input  data_out, read, write, addr, data_write, burst_cnt
`ifdef INSTR_DCD_BURST_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  cs_n, byte_sync, data_in, data_read,
        output data_out, read, write, addr, data_write, burst_cnt
`ifdef INSTR_DCD_BURST_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/instr_dcd_burst.sv
// SPI-side instruction decoder with multi-byte burst support.
// The first byte of a cs_n frame is a command: [7]=write, [6]=auto-increment,
// [ADDR_W-1:0]=start address. Later bytes are write data or read slots.
// Reads are prefetched: the strobe fires the cycle after the triggering byte and
// data_out captures data_read at the end of that cycle.
// Optional feature macro: INSTR_DCD_BURST_ERR_EN (adds sticky err and
// suppresses out-of-range writes / returns 8'hFF for out-of-range reads).
// The interface ADDR_W parameter must match this module's ADDR_W.
module instr_dcd_burst #(
    parameter int ADDR_W    = 6,
    parameter int MAX_ADDR  = 63,
    parameter int MAX_BURST = 16
) (
    input logic               clk,
    input logic               rst_n,
    instr_dcd_burst_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_DATA = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              inc_q;      // auto-increment flag latched from the command byte
    logic              cmd_ev;     // accepted command byte
    logic              wr_ev;      // accepted write-data byte
    logic              rd_ev;      // accepted read-slot byte
    logic [7:0]        cnt_inc;
    logic              cnt_full;   // this data byte is the last one allowed
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] wr_addr;    // address the next write will actually use

    assign cnt_inc  = bus.burst_cnt + 8'd1;
    assign cnt_full = 32'(cnt_inc) >= MAX_BURST;
    assign addr_inc = (32'(bus.addr) == MAX_ADDR) ? '0 : bus.addr + ADDR_W'(1);
    // A write's address advance is applied the cycle after its strobe, so a
    // byte landing on that same edge must already see the advanced address.
    assign wr_addr  = (bus.write && inc_q) ? addr_inc : bus.addr;

`ifdef INSTR_DCD_BURST_ERR_EN
    logic wr_oor;
    logic rd_oor;
    assign wr_oor = 32'(wr_addr) > MAX_ADDR;
    assign rd_oor = 32'(bus.addr) > MAX_ADDR;
`endif

    // State register.
    // NOTE: asynchronous active-low reset; every flop below returns to 0 / IDLE
    // the moment rst_n falls, which is what aborts a frame mid-burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic and classification of the accepted byte.
    // NOTE: every output of this block is given a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state;
        cmd_ev  = 1'b0;
        wr_ev   = 1'b0;
        rd_ev   = 1'b0;
        if (bus.cs_n) begin
            state_d = IDLE;
        end else if (bus.byte_sync) begin
            case (state)
                IDLE: begin
                    cmd_ev  = 1'b1;
                    state_d = bus.data_in[7] ? WR_DATA : RD_DATA;
                end
                WR_DATA: begin
                    wr_ev = 1'b1;
                    if (cnt_full) state_d = DRAIN;
                end
                RD_DATA: begin
                    rd_ev = 1'b1;
                    if (cnt_full) state_d = DRAIN;
                end
                default: ;
            endcase
        end
    end

    // Datapath: address, strobes, write data, read data capture and burst count.
    // NOTE: sequential state is updated with non-blocking assignments only; later
    // assignments in this block deliberately override earlier ones for priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q          <= 1'b0;
            bus.addr       <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.data_write <= '0;
            bus.data_out   <= '0;
            bus.burst_cnt  <= '0;
`ifdef INSTR_DCD_BURST_ERR_EN
            bus.err        <= 1'b0;
`endif
        end else begin
            bus.read  <= 1'b0;
            bus.write <= 1'b0;

            if (bus.write && inc_q) bus.addr <= addr_inc;

            if (bus.read) begin
`ifdef INSTR_DCD_BURST_ERR_EN
                bus.data_out <= rd_oor ? 8'hFF : bus.data_read;
                if (rd_oor) bus.err <= 1'b1;
`else
                bus.data_out <= bus.data_read;
`endif
            end

            if (cmd_ev) begin
                bus.addr      <= bus.data_in[ADDR_W-1:0];
                inc_q         <= bus.data_in[6];
                bus.burst_cnt <= '0;
                bus.read      <= ~bus.data_in[7];
`ifdef INSTR_DCD_BURST_ERR_EN
                bus.err       <= 1'b0;
`endif
            end

            if (wr_ev) begin
                bus.burst_cnt  <= cnt_inc;
                bus.data_write <= bus.data_in;
`ifdef INSTR_DCD_BURST_ERR_EN
                bus.write      <= ~wr_oor;
                if (wr_oor) bus.err <= 1'b1;
`else
                bus.write      <= 1'b1;
`endif
            end

            if (rd_ev) begin
                bus.burst_cnt <= cnt_inc;
                if (!cnt_full) begin
                    bus.read <= 1'b1;
                    if (inc_q) bus.addr <= addr_inc;
                end
            end

            if (bus.cs_n) begin
                bus.data_out  <= '0;
                bus.burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_dcd_burst.sv
// Directed bench for instr_dcd_burst. Three instances share one stimulus stream:
// dut_a (defaults), dut_b (MAX_BURST=2) and dut_c (MAX_ADDR=10).
module tb_instr_dcd_burst;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] mem [64];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_dcd_burst_if #(.ADDR_W(6)) ia ();
    instr_dcd_burst_if #(.ADDR_W(6)) ib ();
    instr_dcd_burst_if #(.ADDR_W(6)) ic ();

    assign ia.cs_n = cs_n;  assign ia.byte_sync = byte_sync;  assign ia.data_in = data_in;
    assign ib.cs_n = cs_n;  assign ib.byte_sync = byte_sync;  assign ib.data_in = data_in;
    assign ic.cs_n = cs_n;  assign ic.byte_sync = byte_sync;  assign ic.data_in = data_in;
    assign ia.data_read = mem[ia.addr];
    assign ib.data_read = mem[ib.addr];
    assign ic.data_read = mem[ic.addr];

    instr_dcd_burst #(.ADDR_W(6), .MAX_ADDR(63), .MAX_BURST(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    instr_dcd_burst #(.ADDR_W(6), .MAX_ADDR(63), .MAX_BURST(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));
    instr_dcd_burst #(.ADDR_W(6), .MAX_ADDR(10), .MAX_BURST(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ic));

    // {read, write, addr, data_write, burst_cnt} of dut_a
    function automatic logic [23:0] snap_a();
        return {ia.read, ia.write, ia.addr, ia.data_write, ia.burst_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled right after this returns: one edge after the byte.
    task automatic send_byte(input logic [7:0] b);
        data_in   = b;
        byte_sync = 1'b1;
        tick();
        byte_sync = 1'b0;
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        tick();
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        vectors++;
        if ({snap_a(), ia.data_out} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", {snap_a(), ia.data_out}, 32'h0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_burst();
        frame_start();
        send_byte(8'hC2);
        vectors++;
        if (snap_a() !== {1'b0, 1'b0, 6'd2, 8'h00, 8'd0}) begin
            miscompares++;
            $display("FAIL wr_cmd: got %h want %h", snap_a(), {1'b0, 1'b0, 6'd2, 8'h00, 8'd0});
        end
        send_byte(8'h11);
        vectors++;
        if (snap_a() !== {1'b0, 1'b1, 6'd2, 8'h11, 8'd1}) begin
            miscompares++;
            $display("FAIL wr_byte0: got %h want %h", snap_a(), {1'b0, 1'b1, 6'd2, 8'h11, 8'd1});
        end
        send_byte(8'h22);
        vectors++;
        if (snap_a() !== {1'b0, 1'b1, 6'd3, 8'h22, 8'd2}) begin
            miscompares++;
            $display("FAIL wr_byte1: got %h want %h", snap_a(), {1'b0, 1'b1, 6'd3, 8'h22, 8'd2});
        end
        send_byte(8'h33);
        vectors++;
        if (snap_a() !== {1'b0, 1'b1, 6'd4, 8'h33, 8'd3}) begin
            miscompares++;
            $display("FAIL wr_byte2: got %h want %h", snap_a(), {1'b0, 1'b1, 6'd4, 8'h33, 8'd3});
        end
        tick();
        vectors++;
        if (snap_a() !== {1'b0, 1'b0, 6'd5, 8'h33, 8'd3}) begin
            miscompares++;
            $display("FAIL wr_after: got %h want %h", snap_a(), {1'b0, 1'b0, 6'd5, 8'h33, 8'd3});
        end
        frame_end();
        vectors++;
        if (snap_a() !== {1'b0, 1'b0, 6'd5, 8'h33, 8'd0}) begin
            miscompares++;
            $display("FAIL wr_frame_end: got %h want %h", snap_a(), {1'b0, 1'b0, 6'd5, 8'h33, 8'd0});
        end
    endtask

    task automatic test_read_burst();
        mem[5] = 8'hA5;
        frame_start();
        send_byte(8'h05);
        vectors++;
        if ({snap_a(), ia.data_out} !== {1'b1, 1'b0, 6'd5, 8'h33, 8'd0, 8'h00}) begin
            miscompares++;
            $display("FAIL rd_cmd: got %h want %h", {snap_a(), ia.data_out},
                     {1'b1, 1'b0, 6'd5, 8'h33, 8'd0, 8'h00});
        end
        tick();
        vectors++;
        if ({ia.read, ia.data_out} !== {1'b0, 8'hA5}) begin
            miscompares++;
            $display("FAIL rd_latency: got %h want %h", {ia.read, ia.data_out}, {1'b0, 8'hA5});
        end
        mem[5] = 8'h5A;
        send_byte(8'h00);
        vectors++;
        if ({snap_a(), ia.data_out} !== {1'b1, 1'b0, 6'd5, 8'h33, 8'd1, 8'hA5}) begin
            miscompares++;
            $display("FAIL rd_slot0: got %h want %h", {snap_a(), ia.data_out},
                     {1'b1, 1'b0, 6'd5, 8'h33, 8'd1, 8'hA5});
        end
        tick();
        vectors++;
        if (ia.data_out !== 8'h5A) begin
            miscompares++;
            $display("FAIL rd_reload: got %h want %h", ia.data_out, 8'h5A);
        end
        send_byte(8'h00);
        vectors++;
        if (snap_a() !== {1'b1, 1'b0, 6'd5, 8'h33, 8'd2}) begin
            miscompares++;
            $display("FAIL rd_slot1: got %h want %h", snap_a(), {1'b1, 1'b0, 6'd5, 8'h33, 8'd2});
        end
        frame_end();
        vectors++;
        if ({ia.data_out, ia.burst_cnt} !== 16'h0000) begin
            miscompares++;
            $display("FAIL rd_frame_end: got %h want %h", {ia.data_out, ia.burst_cnt}, 16'h0000);
        end
    endtask

    task automatic test_wrap();
        frame_start();
        send_byte(8'hFF);
        send_byte(8'h01);
        vectors++;
        if (snap_a() !== {1'b0, 1'b1, 6'd63, 8'h01, 8'd1}) begin
            miscompares++;
            $display("FAIL wrap_top: got %h want %h", snap_a(), {1'b0, 1'b1, 6'd63, 8'h01, 8'd1});
        end
        send_byte(8'h02);
        vectors++;
        if (snap_a() !== {1'b0, 1'b1, 6'd0, 8'h02, 8'd2}) begin
            miscompares++;
            $display("FAIL wrap_zero: got %h want %h", snap_a(), {1'b0, 1'b1, 6'd0, 8'h02, 8'd2});
        end
        frame_end();
    endtask

    task automatic test_burst_limit();
        int n_wr;
        n_wr = 0;
        frame_start();
        send_byte(8'h81);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h40 + 8'(i));
            if (ib.write === 1'b1) n_wr++;
            if (ib.read === 1'b1) n_wr += 100;
        end
        tick();
        vectors++;
        if (n_wr !== 2) begin
            miscompares++;
            $display("FAIL burst_strobes: got %0d want %0d", n_wr, 2);
        end
        vectors++;
        if ({ib.burst_cnt, ib.data_write} !== {8'd2, 8'h41}) begin
            miscompares++;
            $display("FAIL burst_cnt_sat: got %h want %h", {ib.burst_cnt, ib.data_write}, {8'd2, 8'h41});
        end
        frame_end();
    endtask

    task automatic test_cs_abort();
        mem[5] = 8'hA5;
        mem[6] = 8'h66;
        frame_start();
        send_byte(8'h45);
        tick();
        send_byte(8'h00);
        vectors++;
        if ({ia.read, ia.addr, ia.burst_cnt, ia.data_out} !== {1'b1, 6'd6, 8'd1, 8'hA5}) begin
            miscompares++;
            $display("FAIL abort_inc_read: got %h want %h",
                     {ia.read, ia.addr, ia.burst_cnt, ia.data_out}, {1'b1, 6'd6, 8'd1, 8'hA5});
        end
        tick();
        cs_n      = 1'b1;
        data_in   = 8'h99;
        byte_sync = 1'b1;
        tick();
        byte_sync = 1'b0;
        vectors++;
        if ({ia.read, ia.write, ia.data_out, ia.burst_cnt} !== 18'h0) begin
            miscompares++;
            $display("FAIL abort_dropped: got %h want %h",
                     {ia.read, ia.write, ia.data_out, ia.burst_cnt}, 18'h0);
        end
        frame_start();
        send_byte(8'h81);
        vectors++;
        if ({ia.read, ia.write, ia.addr} !== {1'b0, 1'b0, 6'd1}) begin
            miscompares++;
            $display("FAIL abort_next_cmd: got %h want %h", {ia.read, ia.write, ia.addr}, {1'b0, 1'b0, 6'd1});
        end
        send_byte(8'h77);
        vectors++;
        if ({ia.write, ia.addr, ia.data_write} !== {1'b1, 6'd1, 8'h77}) begin
            miscompares++;
            $display("FAIL abort_next_wr: got %h want %h", {ia.write, ia.addr, ia.data_write}, {1'b1, 6'd1, 8'h77});
        end
        frame_end();
    endtask

    task automatic test_reset_midframe();
        frame_start();
        send_byte(8'hC8);
        send_byte(8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({snap_a(), ia.data_out} !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid_frame: got %h want %h", {snap_a(), ia.data_out}, 32'h0);
        end
        rst_n = 1'b1;
        mem[3] = 8'h3C;
        send_byte(8'h03);
        vectors++;
        if ({ia.read, ia.write, ia.addr} !== {1'b1, 1'b0, 6'd3}) begin
            miscompares++;
            $display("FAIL rst_then_cmd: got %h want %h", {ia.read, ia.write, ia.addr}, {1'b1, 1'b0, 6'd3});
        end
        tick();
        vectors++;
        if (ia.data_out !== 8'h3C) begin
            miscompares++;
            $display("FAIL rst_then_read: got %h want %h", ia.data_out, 8'h3C);
        end
        frame_end();
    endtask

    task automatic test_addr_range();
        mem[12] = 8'hC3;
        frame_start();
        send_byte(8'h8C);
`ifdef INSTR_DCD_BURST_ERR_EN
        vectors++;
        if (ic.err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_cmd_clear: got %b want %b", ic.err, 1'b0);
        end
        send_byte(8'h5D);
        vectors++;
        if ({ic.write, ic.err} !== 2'b01) begin
            miscompares++;
            $display("FAIL err_wr_suppress: got %b want %b", {ic.write, ic.err}, 2'b01);
        end
        frame_end();
        vectors++;
        if (ic.err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got %b want %b", ic.err, 1'b1);
        end
        frame_start();
        send_byte(8'h01);
        vectors++;
        if (ic.err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got %b want %b", ic.err, 1'b0);
        end
        frame_end();
        frame_start();
        send_byte(8'h0C);
        tick();
        vectors++;
        if ({ic.data_out, ic.err} !== {8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL err_rd_ff: got %h want %h", {ic.data_out, ic.err}, {8'hFF, 1'b1});
        end
        frame_end();
`else
        send_byte(8'h5D);
        vectors++;
        if ({ic.write, ic.addr, ic.data_write} !== {1'b1, 6'd12, 8'h5D}) begin
            miscompares++;
            $display("FAIL oor_wr_issued: got %h want %h", {ic.write, ic.addr, ic.data_write},
                     {1'b1, 6'd12, 8'h5D});
        end
        frame_end();
        frame_start();
        send_byte(8'h0C);
        tick();
        vectors++;
        if (ic.data_out !== 8'hC3) begin
            miscompares++;
            $display("FAIL oor_rd_issued: got %h want %h", ic.data_out, 8'hC3);
        end
        frame_end();
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_burst_limit();
        test_cs_abort();
        test_reset_midframe();
        test_addr_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
